// File: rtl/mips_decode_alu_if.sv
// Signal bundle between the ID/EX register and the decode/execute core.
// The master drives opcode/operands; the slave returns control bits and registered ALU results.
interface mips_decode_alu_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic [5:0]   opcode;
  logic [5:0]   funct;
  logic [W-1:0] a;
  logic [W-1:0] b_reg;
  logic [W-1:0] seimm;
  logic         regdst;
  logic         branch_eq;
  logic         branch_ne;
  logic         memread;
  logic         memwrite;
  logic         memtoreg;
  logic         regwrite;
  logic         alusrc;
  logic         jump;
  logic [1:0]   aluop;
  logic [3:0]   aluctl;
  logic [W-1:0] result_q;
  logic         zero_q;
  logic         ovf_q;
  logic         out_valid;

  modport master (
    output in_valid, opcode, funct, a, b_reg, seimm,
    input  regdst, branch_eq, branch_ne, memread, memwrite, memtoreg, regwrite, alusrc, jump,
    input  aluop, aluctl, result_q, zero_q, ovf_q, out_valid
  );

  modport slave (
    input  in_valid, opcode, funct, a, b_reg, seimm,
    output regdst, branch_eq, branch_ne, memread, memwrite, memtoreg, regwrite, alusrc, jump,
    output aluop, aluctl, result_q, zero_q, ovf_q, out_valid
  );
endinterface

// File: rtl/mips_decode_alu.sv
// MIPS main decoder, ALU-control decoder and 32-bit ALU with a registered result stage.
// Define ALU_OVF_EN to compute signed overflow for add/sub; otherwise ovf_q is tied to 0.
module mips_decode_alu #(
  parameter int W = 32
) (
  input  logic              clk,
  input  logic              rst,
  mips_decode_alu_if.slave  bus
);
  logic [W-1:0] w_opb;
  logic [W-1:0] w_sum;
  logic [W-1:0] w_diff;
  logic [W-1:0] w_alu;
  logic         w_ovf;
  logic [1:0]   w_aluop;
  logic [3:0]   w_aluctl;
  logic         w_alusrc;

  logic [W-1:0] r_result;
  logic         r_zero;
  logic         r_ovf;
  logic         r_valid;

  // Main decoder; unknown opcodes fall out as an all-zero bubble.
  always_comb begin
    bus.regdst    = 1'b0;
    bus.branch_eq = 1'b0;
    bus.branch_ne = 1'b0;
    bus.memread   = 1'b0;
    bus.memwrite  = 1'b0;
    bus.memtoreg  = 1'b0;
    bus.regwrite  = 1'b0;
    w_alusrc      = 1'b0;
    bus.jump      = 1'b0;
    w_aluop       = 2'b00;
    case (bus.opcode)
      6'b000000: begin bus.regdst = 1'b1; bus.regwrite = 1'b1; w_aluop = 2'b10; end
      6'b100011: begin bus.memread = 1'b1; bus.memtoreg = 1'b1; w_alusrc = 1'b1; bus.regwrite = 1'b1; end
      6'b101011: begin bus.memwrite = 1'b1; w_alusrc = 1'b1; end
      6'b000100: begin bus.branch_eq = 1'b1; w_aluop = 2'b01; end
      6'b000101: begin bus.branch_ne = 1'b1; w_aluop = 2'b01; end
      6'b001000: begin w_alusrc = 1'b1; bus.regwrite = 1'b1; end
      6'b000010: bus.jump = 1'b1;
      default:   ;
    endcase
  end

  always_comb begin
    w_aluctl = 4'b0010;
    case (w_aluop)
      2'b01: w_aluctl = 4'b0110;
      2'b10: begin
        case (bus.funct)
          6'b100000: w_aluctl = 4'b0010;
          6'b100010: w_aluctl = 4'b0110;
          6'b100100: w_aluctl = 4'b0000;
          6'b100101: w_aluctl = 4'b0001;
          6'b101010: w_aluctl = 4'b0111;
          6'b100111: w_aluctl = 4'b1100;
          default:   w_aluctl = 4'b1111;
        endcase
      end
      default: w_aluctl = 4'b0010;
    endcase
  end

  assign bus.alusrc = w_alusrc;
  assign bus.aluop  = w_aluop;
  assign bus.aluctl = w_aluctl;

  assign w_opb  = w_alusrc ? bus.seimm : bus.b_reg;
  assign w_sum  = bus.a + w_opb;
  assign w_diff = bus.a - w_opb;

  always_comb begin
    w_alu = '0;
    case (w_aluctl)
      4'b0000: w_alu = bus.a & w_opb;
      4'b0001: w_alu = bus.a | w_opb;
      4'b0010: w_alu = w_sum;
      4'b0110: w_alu = w_diff;
      4'b0111: w_alu = ($signed(bus.a) < $signed(w_opb)) ? {{(W-1){1'b0}}, 1'b1} : '0;
      4'b1100: w_alu = ~(bus.a | w_opb);
      default: w_alu = '0;
    endcase
  end

`ifdef ALU_OVF_EN
  always_comb begin
    w_ovf = 1'b0;
    if (w_aluctl == 4'b0010)
      w_ovf = (bus.a[W-1] == w_opb[W-1]) && (w_sum[W-1] != bus.a[W-1]);
    else if (w_aluctl == 4'b0110)
      w_ovf = (bus.a[W-1] != w_opb[W-1]) && (w_diff[W-1] != bus.a[W-1]);
  end
`else
  assign w_ovf = 1'b0;
`endif

  // Captured every edge regardless of in_valid; out_valid qualifies the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_result <= w_alu;
      r_zero   <= (w_alu == '0);
      r_ovf    <= w_ovf;
      r_valid  <= bus.in_valid;
    end
  end

  assign bus.result_q  = r_result;
  assign bus.zero_q    = r_zero;
  assign bus.ovf_q     = r_ovf;
  assign bus.out_valid = r_valid;
endmodule

// File: tb/tb_mips_decode_alu.sv
// Directed-vector bench for mips_decode_alu: decode bits, ALU results, async reset, overflow.
// Control bundle order: {regdst,branch_eq,branch_ne,memread,memwrite,memtoreg,regwrite,alusrc,jump}.
module tb_mips_decode_alu;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  mips_decode_alu_if #(.W(32)) bus ();

  mips_decode_alu #(.W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] ctl_vec();
    return {bus.regdst, bus.branch_eq, bus.branch_ne, bus.memread, bus.memwrite,
            bus.memtoreg, bus.regwrite, bus.alusrc, bus.jump};
  endfunction

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic v);
    @(negedge clk);
    bus.opcode = op; bus.funct = fn; bus.a = a; bus.b_reg = b; bus.seimm = imm; bus.in_valid = v;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks comb decode right after drive, then the registered ALU outputs one edge later.
  task automatic expect_vec(input string name, input logic [8:0] ctl, input logic [1:0] op_cls,
                            input logic [3:0] actl, input logic [31:0] res, input logic z,
                            input logic v);
    n_vec++;
    if (ctl_vec() !== ctl || bus.aluop !== op_cls || bus.aluctl !== actl) begin
      n_err++;
      $display("FAIL %s decode: ctl=%b aluop=%b aluctl=%b, required ctl=%b aluop=%b aluctl=%b",
               name, ctl_vec(), bus.aluop, bus.aluctl, ctl, op_cls, actl);
    end
    tick();
    n_vec++;
    if (bus.result_q !== res || bus.zero_q !== z || bus.out_valid !== v) begin
      n_err++;
      $display("FAIL %s result: result_q=%h zero_q=%b out_valid=%b, required %h %b %b",
               name, bus.result_q, bus.zero_q, bus.out_valid, res, z, v);
    end
    $display("vec %-10s op=%b fn=%b result_q=%h zero_q=%b", name, bus.opcode, bus.funct,
             bus.result_q, bus.zero_q);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.opcode = 6'b000000; bus.funct = 6'b100000;
    bus.a = 32'd3; bus.b_reg = 32'd4; bus.seimm = 32'd0;
    repeat (2) tick();
    n_vec++;
    if (bus.result_q !== 32'd0 || bus.zero_q !== 1'b0 || bus.ovf_q !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset: result_q=%h zero_q=%b ovf_q=%b out_valid=%b, required 0 0 0 0",
               bus.result_q, bus.zero_q, bus.ovf_q, bus.out_valid);
    end
    $display("vec reset      result_q=%h out_valid=%b", bus.result_q, bus.out_valid);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_main_decode();
    drive(6'b000000, 6'b100000, 32'd5, 32'd7, 32'd0, 1'b1);
    expect_vec("r_add", 9'b100000100, 2'b10, 4'b0010, 32'd12, 1'b0, 1'b1);
    drive(6'b000100, 6'b000000, 32'd9, 32'd9, 32'd0, 1'b1);
    expect_vec("beq", 9'b010000000, 2'b01, 4'b0110, 32'd0, 1'b1, 1'b1);
    drive(6'b000101, 6'b000000, 32'd9, 32'd4, 32'd0, 1'b1);
    expect_vec("bne", 9'b001000000, 2'b01, 4'b0110, 32'd5, 1'b0, 1'b1);
    drive(6'b100011, 6'b000000, 32'h100, 32'h55, 32'hFFFFFFFC, 1'b1);
    expect_vec("lw", 9'b000101110, 2'b00, 4'b0010, 32'h000000FC, 1'b0, 1'b1);
    drive(6'b101011, 6'b111111, 32'h200, 32'h1234, 32'h10, 1'b1);
    expect_vec("sw", 9'b000010010, 2'b00, 4'b0010, 32'h210, 1'b0, 1'b1);
    drive(6'b001000, 6'b000000, 32'd10, 32'd99, 32'hFFFFFFF6, 1'b1);
    expect_vec("addi", 9'b000000110, 2'b00, 4'b0010, 32'd0, 1'b1, 1'b1);
    drive(6'b000010, 6'b100010, 32'd1, 32'd2, 32'd0, 1'b1);
    expect_vec("j", 9'b000000001, 2'b00, 4'b0010, 32'd3, 1'b0, 1'b1);
  endtask

  task automatic test_rtype_funct();
    drive(6'b000000, 6'b100010, 32'd3, 32'd5, 32'd0, 1'b1);
    expect_vec("sub", 9'b100000100, 2'b10, 4'b0110, 32'hFFFFFFFE, 1'b0, 1'b1);
    drive(6'b000000, 6'b100100, 32'hF0F0_1234, 32'h0FF0_00FF, 32'd0, 1'b1);
    expect_vec("and", 9'b100000100, 2'b10, 4'b0000, 32'h00F0_0034, 1'b0, 1'b1);
    drive(6'b000000, 6'b100101, 32'hF000_0001, 32'h0000_0F00, 32'd0, 1'b1);
    expect_vec("or", 9'b100000100, 2'b10, 4'b0001, 32'hF000_0F01, 1'b0, 1'b1);
    drive(6'b000000, 6'b101010, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1);
    expect_vec("slt_neg", 9'b100000100, 2'b10, 4'b0111, 32'd1, 1'b0, 1'b1);
    drive(6'b000000, 6'b101010, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b1);
    expect_vec("slt_pos", 9'b100000100, 2'b10, 4'b0111, 32'd0, 1'b1, 1'b1);
    drive(6'b000000, 6'b100111, 32'd0, 32'd0, 32'd0, 1'b1);
    expect_vec("nor", 9'b100000100, 2'b10, 4'b1100, 32'hFFFFFFFF, 1'b0, 1'b1);
  endtask

  task automatic test_unknown();
    drive(6'b111111, 6'b100000, 32'd4, 32'd6, 32'd1, 1'b1);
    expect_vec("bad_op", 9'b000000000, 2'b00, 4'b0010, 32'd10, 1'b0, 1'b1);
    drive(6'b000000, 6'b000111, 32'd4, 32'd6, 32'd0, 1'b1);
    expect_vec("bad_funct", 9'b100000100, 2'b10, 4'b1111, 32'd0, 1'b1, 1'b1);
    drive(6'b000000, 6'b100000, 32'd20, 32'd22, 32'd0, 1'b0);
    expect_vec("invalid", 9'b100000100, 2'b10, 4'b0010, 32'd42, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    drive(6'b000000, 6'b100000, 32'd5, 32'd7, 32'd0, 1'b1);
    expect_vec("pre_rst", 9'b100000100, 2'b10, 4'b0010, 32'd12, 1'b0, 1'b1);
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if (bus.result_q !== 32'd0 || bus.out_valid !== 1'b0 || bus.zero_q !== 1'b0) begin
      n_err++;
      $display("FAIL async_rst: result_q=%h out_valid=%b zero_q=%b, required 0 0 0",
               bus.result_q, bus.out_valid, bus.zero_q);
    end
    n_vec++;
    if (ctl_vec() !== 9'b100000100 || bus.aluctl !== 4'b0010) begin
      n_err++;
      $display("FAIL rst_comb: ctl=%b aluctl=%b, required 100000100 0010", ctl_vec(), bus.aluctl);
    end
    $display("vec async_rst  result_q=%h out_valid=%b", bus.result_q, bus.out_valid);
    #1 rst = 1'b0;
    tick();
    n_vec++;
    if (bus.result_q !== 32'd12 || bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL post_rst: result_q=%h out_valid=%b, required 0000000c 1",
               bus.result_q, bus.out_valid);
    end
    $display("vec post_rst   result_q=%h out_valid=%b", bus.result_q, bus.out_valid);
  endtask

  task automatic test_overflow();
    logic exp_ovf;
`ifdef ALU_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    drive(6'b000000, 6'b100000, 32'h7FFFFFFF, 32'd1, 32'd0, 1'b1);
    expect_vec("add_ovf", 9'b100000100, 2'b10, 4'b0010, 32'h80000000, 1'b0, 1'b1);
    n_vec++;
    if (bus.ovf_q !== exp_ovf) begin
      n_err++;
      $display("FAIL add_ovf flag: ovf_q=%b, required %b", bus.ovf_q, exp_ovf);
    end
    drive(6'b000000, 6'b100010, 32'h80000000, 32'd1, 32'd0, 1'b1);
    expect_vec("sub_ovf", 9'b100000100, 2'b10, 4'b0110, 32'h7FFFFFFF, 1'b0, 1'b1);
    n_vec++;
    if (bus.ovf_q !== exp_ovf) begin
      n_err++;
      $display("FAIL sub_ovf flag: ovf_q=%b, required %b", bus.ovf_q, exp_ovf);
    end
    // Same operand signs on subtract, or an OR whose sum would overflow: never flagged.
    drive(6'b000000, 6'b100101, 32'h7FFFFFFF, 32'd1, 32'd0, 1'b1);
    expect_vec("or_noovf", 9'b100000100, 2'b10, 4'b0001, 32'h7FFFFFFF, 1'b0, 1'b1);
    n_vec++;
    if (bus.ovf_q !== 1'b0) begin
      n_err++;
      $display("FAIL or_noovf flag: ovf_q=%b, required 0", bus.ovf_q);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_main_decode();
    test_rtype_funct();
    test_unknown();
    test_async_reset();
    test_overflow();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
